// File: rtl/spi_target_regs.sv
// -----------------------------------------------------------------------------
// spi_target_regs
//   SPI mode-0 target with a byte-addressed register file, plus a local host
//   port onto the same registers. The SPI pins are oversampled in the wb_clk_i
//   domain. Each SCLK half-period must last at least 6 wb_clk_i cycles.
//
//   Frame format (MSB first): one command byte {rw, addr}, then data bytes.
//   rw=1 reads, rw=0 writes. The address auto-increments after each data
//   byte and wraps modulo 2**ADDR_W. Command bits above the address field
//   must be zero, otherwise err_o pulses and the rest of the frame is ignored.
//
// Ports
//   wb_clk_i, wb_rst_i    system clock, synchronous active-high reset
//   spi_clk/cs/mosi       asynchronous SPI inputs (CS active low)
//   spi_miso              target data out, 0 when not selected
//   reg_addr_i/we_i/wdata_i  local write port
//   reg_rdata_o           local read data, registered, read-before-write
//   busy_o                frame in progress
//   frame_done_o          1-cycle pulse when CS deasserts after a started frame
//   err_o                 1-cycle pulse on an out-of-range command address
// -----------------------------------------------------------------------------
module spi_target_regs #(
    parameter int ADDR_W = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic              reg_we_i,
    input  logic [7:0]        reg_wdata_i,
    output logic [7:0]        reg_rdata_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DISCARD} state_e;

    // Synchronisers: [0] and [1] form the 2-flop synchroniser, [2] is the
    // previous synchronised value used for edge detection.
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        shreg_q;
    logic [ADDR_W-1:0] addr_q;
    logic              armed_q;
    logic              miso_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        rdata_q;
    logic [7:0]        regs_q [DEPTH];

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, cs_edge;
    logic              last_bit;
    logic [7:0]        rx_byte_d;
    logic              spi_we_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_edge   = cs_rise | cs_fall;

    assign last_bit  = (bit_cnt_q == 3'd7);
    assign rx_byte_d = {shreg_q, mosi_sync_q[1]};
    // A completed data byte in WR is written this cycle, unless a CS edge
    // (which takes priority) arrives in the same cycle.
    assign spi_we_d  = (state_q == WR) && sclk_rise && !cs_edge && last_bit;

    // Register file and local read port.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: the register file is cleared on reset because software
            // relies on every register reading 0 after reset.
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking reads see pre-write values, so rdata_q is
            // read-before-write; of two writes to the same entry in this
            // block the later one (SPI) wins.
            rdata_q <= regs_q[reg_addr_i];
            if (reg_we_i) regs_q[reg_addr_i] <= reg_wdata_i;
            if (spi_we_d) regs_q[addr_q] <= rx_byte_d;
        end
    end

    // Frame state machine with registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            armed_q   <= 1'b0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Only a CS fall seen after CS was high starts a frame, so a
            // frame cut by reset is never picked up halfway through.
            if (cs_sync_q[1]) armed_q <= 1'b1;

            if (state_q == IDLE) begin
                if (cs_fall && armed_q) begin
                    state_q   <= CMD;
                    bit_cnt_q <= '0;
                end
            end else if (cs_rise) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
                miso_q  <= 1'b0;
            end else if (!cs_fall) begin
                case (state_q)
                    CMD: begin
                        if (sclk_rise) begin
                            shreg_q   <= rx_byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                addr_q <= rx_byte_d[ADDR_W-1:0];
                                if ((rx_byte_d[6:0] >> ADDR_W) != 7'd0) begin
                                    err_q   <= 1'b1;
                                    state_q <= DISCARD;
                                end else if (rx_byte_d[7]) begin
                                    state_q <= RD;
                                end else begin
                                    state_q <= WR;
                                end
                            end
                        end
                    end
                    WR: begin
                        if (sclk_rise) begin
                            shreg_q   <= rx_byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    RD: begin
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) addr_q <= addr_q + ADDR_W'(1);
                        end else if (sclk_fall) begin
                            // First fall of a byte snapshots the register;
                            // the MSB goes out directly, the rest is shifted.
                            if (bit_cnt_q == 3'd0) begin
                                shreg_q <= regs_q[addr_q][6:0];
                                miso_q  <= regs_q[addr_q][7];
                            end else begin
                                shreg_q <= {shreg_q[5:0], 1'b0};
                                miso_q  <= shreg_q[6];
                            end
                        end
                    end
                    default: miso_q <= 1'b0;
                endcase
            end
        end
    end

    assign spi_miso     = miso_q;
    assign reg_rdata_o  = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign err_o        = err_q;

endmodule
